// File: rtl/sha1_arbiter.sv
// -----------------------------------------------------------------------------
// sha1_arbiter
//
// Shares one SHA-1 core between two requesters. A job is granted round-robin,
// the winner's 512-bit block is latched onto the core's message input, the
// core is switched on, and when the core reports finish the digest is latched
// and the owner receives a one-cycle done pulse.
//
// Parameters
//   TIMEOUT_CYCLES  maximum number of RUN cycles before a job is aborted
//                   (only meaningful when the watchdog is compiled in)
//
// Compile-time option
//   SHA1_ARB_TIMEOUT_EN  when defined, a watchdog aborts jobs whose core never
//                        finishes; done and err then pulse together and
//                        digest_out keeps its previous value. When undefined,
//                        err is tied low and RUN waits for finish forever.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   req0, req1   requests, held high until the matching done
//   msg0, msg1   512-bit message blocks, sampled only at grant
//   done0, done1 one-cycle completion pulses
//   digest_out   160-bit digest of the last successfully completed job
//   err          one-cycle pulse together with done when the job was aborted
//   busy         high whenever the arbiter is not IDLE
//   core_on      drives the core's on input
//   core_msg     drives the core's message_in
//   core_digest  core's digest_out
//   core_finish  core's finish flag
// -----------------------------------------------------------------------------
module sha1_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [511:0] msg0,
  input  logic [511:0] msg1,
  output logic         done0,
  output logic         done1,
  output logic [159:0] digest_out,
  output logic         err,
  output logic         busy,
  output logic         core_on,
  output logic [511:0] core_msg,
  input  logic [159:0] core_digest,
  input  logic         core_finish
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state;

  // Requester that owns the job in flight (0 or 1).
  logic owner;

  // Requester granted most recently; a tie goes to the other one.
  logic last_served;

  // Requester that would win if a grant happened this cycle.
  logic pick;

`ifdef SHA1_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Counts RUN cycles of the current job; the abort fires on the RUN cycle
  // that would be the TIMEOUT_CYCLES-th one without a finish.
  logic [CNT_W-1:0] timeout_cnt;
`else
  // Without the watchdog a job can never be aborted.
  assign err = 1'b0;
`endif

  // Round-robin choice. With a single request that requester wins outright;
  // with both requests the one not served last wins, so a requester that
  // keeps re-requesting cannot starve the other.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last_served;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

  // Main controller. All outputs are registered here so that core_on,
  // core_msg and the done/err pulses are glitch-free and change only on a
  // clock edge (or immediately on reset, which abandons any job in flight
  // without a done pulse). core_on is only ever set from GRANT and is cleared
  // on every exit from RUN, which guarantees at least one low cycle between
  // consecutive jobs. done/err default low each cycle so they are single
  // cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      core_on     <= 1'b0;
      core_msg    <= '0;
      digest_out  <= '0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      busy        <= 1'b0;
`ifdef SHA1_ARB_TIMEOUT_EN
      err         <= 1'b0;
      timeout_cnt <= '0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
`ifdef SHA1_ARB_TIMEOUT_EN
      err   <= 1'b0;
`endif

      case (state)
        // Waiting for work. The chosen block is latched here and only here,
        // so later changes on msg0/msg1 cannot disturb a running job, and a
        // request from the other side simply stays pending until we return.
        IDLE: begin
          core_on <= 1'b0;
          if (req0 || req1) begin
            owner       <= pick;
            last_served <= pick;
            core_msg    <= pick ? msg1 : msg0;
            busy        <= 1'b1;
            state       <= GRANT;
          end
        end

        // One setup cycle: switch the core on and arm the watchdog.
        GRANT: begin
          core_on <= 1'b1;
`ifdef SHA1_ARB_TIMEOUT_EN
          timeout_cnt <= '0;
`endif
          state   <= RUN;
        end

        // Core is hashing. The owner's req is deliberately ignored here so a
        // requester that lets go early still gets its done and digest.
        // A real finish takes priority over a coincident timeout.
        RUN: begin
          if (core_finish) begin
            digest_out <= core_digest;
            done0      <= ~owner;
            done1      <= owner;
            core_on    <= 1'b0;
            state      <= DRAIN;
          end
`ifdef SHA1_ARB_TIMEOUT_EN
          else if (timeout_cnt == CNT_LAST) begin
            done0   <= ~owner;
            done1   <= owner;
            err     <= 1'b1;
            core_on <= 1'b0;
            state   <= DRAIN;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
`endif
        end

        // Core is off; wait for it to drop finish before accepting new work
        // so a stale finish cannot complete the next job instantly.
        DRAIN: begin
          core_on <= 1'b0;
          if (!core_finish) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          core_on <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sha1_arbiter.md
SHA1_ARBITER -- requirements
Module: sha1_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023; maximum core_on-high cycles before abort.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  requester hashing requests; held high until the matching done.
REQ-005 msg0, msg1  input  512 each  requester message blocks; sampled only at grant.
REQ-006 done0, done1  output  1 each  one-cycle completion pulse to requester 0 or 1.
REQ-007 digest_out  output  160  latched result of the last completed job.
REQ-008 err  output  1  one-cycle pulse coincident with done when the job aborted.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 core_on  output  1  drives the core's on input.
REQ-011 core_msg  output  512  drives the core's message_in.
REQ-012 core_digest  input  160  core's digest_out.
REQ-013 core_finish  input  1  core's finish.

Function
REQ-014 FSM states: IDLE, GRANT, RUN, DRAIN.
REQ-015 IDLE: if either req is high, select one requester, latch its msg into core_msg, and go to GRANT on the next edge.
REQ-016 Arbitration is round-robin: when both req are high, grant the requester not served last; single requests are granted immediately.
REQ-017 GRANT: assert core_on, clear the timeout counter, and go to RUN; latency from req to core_on high is 2 cycles.
REQ-018 RUN: hold core_on high and core_msg stable; on core_finish high, capture core_digest into digest_out, pulse done of the owner, and go to DRAIN.
REQ-019 DRAIN: drive core_on low and stay until core_finish is low, with a minimum of 1 cycle; then go to IDLE.
REQ-020 core_on is never high in IDLE or DRAIN, so a new job always starts with at least 1 cycle of core_on low.
REQ-021 Deasserting the owner's req during GRANT/RUN does not abort the job; done is still pulsed and digest_out is still updated.
REQ-022 A new req from the non-owner during a job is held pending and considered only on return to IDLE; no request is lost.
REQ-023 msg inputs changing after grant have no effect; core_msg changes only on the IDLE->GRANT transition.
REQ-024 done0 and done1 are never high in the same cycle; err is high only together with a done.
REQ-025 The last-served pointer updates at grant.

Reset
REQ-026 When reset is low, the block asynchronously enters IDLE with these values:
- core_on=0, core_msg=0, digest_out=0;
- done0=done1=err=busy=0;
- timeout counter=0;
- last-served pointer=requester 1, so requester 0 wins the first tie.
REQ-027 Reset asserted mid-job abandons the job without a done pulse; core_on drops immediately.
REQ-028 After reset release, the first grant is possible on the first clk edge.

Configuration
REQ-029 Macro SHA1_ARB_TIMEOUT_EN compiles in the watchdog.
REQ-030 With SHA1_ARB_TIMEOUT_EN defined, the watchdog behaves as follows:
- the counter increments each RUN cycle;
- on reaching TIMEOUT_CYCLES without core_finish, the owner's done and err both pulse;
- digest_out is left unchanged;
- the FSM goes to DRAIN.
REQ-031 Without SHA1_ARB_TIMEOUT_EN, no counter exists, err is tied to 0, and RUN waits for core_finish indefinitely.

Verification
REQ-032 Single request: req0=1, msg0=SHA-1 padded "abc" block, real core attached -> core_on rises 2 cycles later; done0 pulses once; digest_out equals the core's digest_out at finish; err=0.
REQ-033 Simultaneous requests after reset: req0=req1=1 with a stub core finishing 170 cycles after on -> order done0 then done1; core_on low at least 1 cycle between jobs; core_msg=msg1 during the second job.
REQ-034 Fairness: req0 and req1 held high for 6 jobs -> grants alternate 0,1,0,1,0,1; no done pulses overlap.
REQ-035 Requester drop: req1 deasserted 10 cycles into RUN -> done1 still pulses and digest_out is updated.
REQ-036 Mid-job reset: reset low for 3 cycles during RUN -> core_on=0 and busy=0 asynchronously, no done; a fresh req0 afterwards completes normally.
REQ-037 Timeout, SHA1_ARB_TIMEOUT_EN defined with TIMEOUT_CYCLES=50 and a stub that never finishes -> done0 and err pulse together 50 RUN cycles after core_on rises; digest_out keeps its prior value; core_on low in DRAIN.
